// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART types and constants used by the transmit controller and the bit counter.
package uart_tx_ctrl_pkg;

  typedef logic bit_t;

  localparam int unsigned bitspertx = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_tx_state_t;

  // The parity bit sent for a word, given the odd/even selection.
  function automatic bit_t parity_of(input logic [bitspertx-1:0] data, input bit_t odd);
    return bit_t'(^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: while enabled, counts 0..ClksPerBit-1 and flags the last count with tick.
module uart_baud_tick #(
  parameter int unsigned ClksPerBit = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == CntW'(ClksPerBit - 1));
    cnt_d = cnt_q;
    if (clear || !enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames one word per request (start, LSB-first data, optional
// parity, stop) and drives the external bit counter that marks the end of the data phase.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = bitspertx,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 increment_bit_counter,
  output logic                 reset_bit_counter,
  input  logic                 bit_counter
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  bit_t                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 tick;
  logic                 baud_clear;

  uart_baud_tick #(
    .ClksPerBit(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .enable(state_q != StIdle),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d               = state_q;
    shift_d               = shift_q;
    parity_d              = parity_q;
    tx_done               = 1'b0;
    increment_bit_counter = 1'b0;
    reset_bit_counter     = 1'b0;
    baud_clear            = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          shift_d           = tx_data;
          parity_d          = parity_of(tx_data, bit_t'(PARITY_ODD != 0));
          reset_bit_counter = 1'b1;
          baud_clear        = 1'b1;
          state_d           = StStart;
        end
      end
      StStart: begin
        if (tick) state_d = StData;
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          // The sticky flag means the bit just finished was the last; no increment for it.
          if (bit_counter) begin
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            increment_bit_counter = 1'b1;
          end
        end
      end
      StParity: begin
        if (tick) state_d = StStop;
      end
      StStop: begin
        if (tick) begin
          tx_done           = 1'b1;
          reset_bit_counter = 1'b1;
          state_d           = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is registered from the next state so it changes with the state itself.
    unique case (state_d)
      StStart:  serial_d = 1'b0;
      StData:   serial_d = shift_d[0];
      StParity: serial_d = parity_d;
      default:  serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      parity_q <= 1'b0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      serial_q <= serial_d;
    end
  end

  assign tx_serial = serial_q;
  assign tx_busy   = (state_q != StIdle);

endmodule
